demux_scan_driver: RTL and testbench
====================================

Name: demux_scan_driver

Overview:
- Upstream sequencer for the 1-to-16 demultiplexer with enable (ports e, i, s).
- Accepts a 16-bit frame over a valid/ready handshake.
- Walks the select through all 16 channels, presenting the matching frame bit on i with e asserted (active-low), then pulses done.
- Turns the combinational demux into a timed serial-to-16-line distributor.

Parameters:
- DWELL, 1: clock cycles each channel is held on s/i; legal range 1..255.
- LSB_FIRST, 1: 1 = channel order 0→15; 0 = channel order 15→0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  frame offered
- in_ready  out  1  block can accept a frame; high only in IDLE
- in_data  in  16  frame; bit k is the value driven for channel k
- e  out  1  demux enable, active-low; 0 only while scanning
- i  out  1  demux data input
- s  out  4  demux select
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse after the last channel

Behaviour:
- All outputs are registered, except in_ready, which is decoded from state.
- Reset values: e=1, i=0, s=0, busy=0, done=0, state=IDLE, so in_ready=1.
- States: IDLE, SCAN, DONE.
- IDLE:
  - e=1, i=0, s=0, done=0.
  - On an edge where in_valid && in_ready, in_data is captured into an internal frame register and the state goes to SCAN.
  - First channel (0 if LSB_FIRST, else 15) appears on s on the next cycle, with i=frame[s] and e=0.
- SCAN:
  - Each channel is held exactly DWELL cycles, counted by a dwell counter of width clog2(DWELL+1).
  - The channel then advances by +1 (LSB_FIRST=1) or −1 (LSB_FIRST=0).
  - i always equals frame[s] in the same cycle.
  - After the last channel (15 or 0) completes its dwell, the state goes to DONE.
- DONE: lasts one cycle; e=1, i=0, s=0, done=1, busy=1, in_ready=0. The state then returns to IDLE.
- Timing: first scan cycle is 1 cycle after acceptance; the DONE cycle is 16*DWELL+1 cycles after acceptance; the next acceptance is possible at 16*DWELL+2.
- in_valid and in_data are ignored outside IDLE; the source must hold in_valid until it sees in_ready.
- Changes on in_data during SCAN have no effect on i.
- Channel counter wrap: no wrap ever occurs; the terminal channel ends the scan.
- Reset while in SCAN or DONE:
  - At that edge the state becomes IDLE and all outputs take reset values.
  - No done pulse is produced; the partial frame is discarded.
- Reset and in_valid together: reset wins; no frame is accepted.
- DWELL=1: s changes every cycle; the dwell counter is unused but legal.

Optional Feature:
- Macro: DEMUX_SCAN_MASK_EN
- With the macro defined:
  - Adds port in_mask (in, 16); it is captured with in_data on acceptance.
  - Channels whose mask bit is 1 are skipped and consume zero cycles; order and dwell are unchanged for unmasked channels.
  - The scan ends after the last unmasked channel in scan order.
  - All-ones mask: SCAN is bypassed entirely. IDLE goes directly to DONE on the cycle after acceptance, and e never goes low.
- Without the macro: the in_mask port is absent and all 16 channels are always scanned.

Test Plan:
- Reset: hold rst=1 for 2 cycles while in_valid=1 → e=1, i=0, s=0, busy=0, done=0, in_ready=1 throughout; no frame accepted.
- DWELL=1, LSB_FIRST=1, in_data=16'hA5C3 accepted at cycle 0:
  - Cycles 1..16: s=0..15, e=0, i=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - Cycle 17: done=1, e=1.
  - Cycle 18: in_ready=1.
- DWELL=3, LSB_FIRST=0, in_data=16'h8001 → s=15 for 3 cycles with i=1, s=14..1 each for 3 cycles with i=0, s=0 for 3 cycles with i=1; done at cycle 49.
- Back-to-back: in_valid held high with frame 16'hFFFF, then 16'h0000 offered immediately after the first accept:
  - Second frame is not accepted during SCAN or DONE.
  - Second frame is accepted on the IDLE cycle (cycle 18 for DWELL=1); its scan shows i=0 on all channels.
- Mid-scan reset: DWELL=1, rst=1 for one cycle while s=7 → next cycle e=1, s=0, busy=0, in_ready=1; done is never asserted for that frame.
- DEMUX_SCAN_MASK_EN:
  - mask=16'hFFFE, data=16'h0001 → exactly one cycle with s=0, i=1, e=0, then done.
  - mask=16'hFFFF → done=1 on cycle 1 after accept, with e=1 throughout.

Source files
------------

// File: rtl/demux_scan_driver.sv
// demux_scan_driver: accepts a 16-bit frame over valid/ready and walks a
// 1-to-16 demux select through every channel, driving the matching frame
// bit with the active-low enable asserted, then pulses done for one cycle.
// Optional feature macro: DEMUX_SCAN_MASK_EN (adds in_mask; masked channels
// are skipped and consume no cycles).
module demux_scan_driver #(
    parameter int unsigned DWELL     = 1,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
`ifdef DEMUX_SCAN_MASK_EN
    input  logic [15:0] in_mask,
`endif
    output logic        e,
    output logic        i,
    output logic [3:0]  s,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     frame_q, frame_d;
    logic [15:0]     skip_q, skip_d;
    logic [CW-1:0]   dwell_q, dwell_d;
    logic            e_q, e_d;
    logic            i_q, i_d;
    logic [3:0]      s_q, s_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [15:0]     in_skip_c;
    logic [4:0]      first_c;
    logic [4:0]      next_c;

    // Scan position <-> channel number; the mapping is its own inverse.
    function automatic logic [3:0] pos2ch(input logic [3:0] p);
        return LSB_FIRST ? p : (4'd15 - p);
    endfunction

    // First non-skipped channel at scan position >= start; bit 4 = found.
    function automatic logic [4:0] find_ch(input logic [15:0] skip, input logic [4:0] start);
        logic [4:0] r;
        r = 5'd0;
        for (int p = 15; p >= 0; p--) begin
            if ((5'(p) >= start) && !skip[pos2ch(4'(p))]) begin
                r = {1'b1, pos2ch(4'(p))};
            end
        end
        return r;
    endfunction

`ifdef DEMUX_SCAN_MASK_EN
    assign in_skip_c = in_mask;
`else
    assign in_skip_c = 16'h0000;
`endif

    assign first_c  = find_ch(in_skip_c, 5'd0);
    assign next_c   = find_ch(skip_q, {1'b0, pos2ch(s_q)} + 5'd1);

    assign in_ready = (state_q == ST_IDLE);
    assign e        = e_q;
    assign i        = i_q;
    assign s        = s_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= 16'h0000;
            skip_q  <= 16'h0000;
            dwell_q <= '0;
            e_q     <= 1'b1;
            i_q     <= 1'b0;
            s_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            skip_q  <= skip_d;
            dwell_q <= dwell_d;
            e_q     <= e_d;
            i_q     <= i_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        skip_d  = skip_q;
        dwell_d = dwell_q;
        e_d     = e_q;
        i_d     = i_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                e_d    = 1'b1;
                i_d    = 1'b0;
                s_d    = 4'd0;
                busy_d = 1'b0;
                if (in_valid) begin
                    frame_d = in_data;
                    skip_d  = in_skip_c;
                    busy_d  = 1'b1;
                    if (first_c[4]) begin
                        state_d = ST_SCAN;
                        s_d     = first_c[3:0];
                        i_d     = in_data[first_c[3:0]];
                        e_d     = 1'b0;
                        dwell_d = CW'(1);
                    end else begin
                        // Every channel masked: nothing to scan.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_SCAN: begin
                if (dwell_q == CW'(DWELL)) begin
                    if (next_c[4]) begin
                        s_d     = next_c[3:0];
                        i_d     = frame_q[next_c[3:0]];
                        dwell_d = CW'(1);
                    end else begin
                        state_d = ST_DONE;
                        e_d     = 1'b1;
                        i_d     = 1'b0;
                        s_d     = 4'd0;
                        done_d  = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + CW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                e_d     = 1'b1;
                i_d     = 1'b0;
                s_d     = 4'd0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                e_d     = 1'b1;
                i_d     = 1'b0;
                s_d     = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_demux_scan_driver.sv
// Scoreboard bench for demux_scan_driver: two instances (DWELL=1 ascending,
// DWELL=3 descending) share one stimulus stream; a reference model expands
// each accepted frame into its expected per-cycle output trace.
module tb_demux_scan_driver;

    typedef struct packed {
        logic       e;
        logic       i;
        logic [3:0] s;
        logic       busy;
        logic       done;
        logic       rdy;
    } obs_t;

    localparam obs_t IDLE_OBS = {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
`ifdef DEMUX_SCAN_MASK_EN
    logic [15:0] in_mask;
`endif

    logic       rdy0, e0, i0, busy0, done0;
    logic [3:0] s0;
    logic       rdy1, e1, i1, busy1, done1;
    logic [3:0] s1;

    obs_t q0[$];
    obs_t q1[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    demux_scan_driver #(.DWELL(1), .LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
`ifdef DEMUX_SCAN_MASK_EN
        .in_mask(in_mask),
`endif
        .e(e0), .i(i0), .s(s0), .busy(busy0), .done(done0)
    );

    demux_scan_driver #(.DWELL(3), .LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
`ifdef DEMUX_SCAN_MASK_EN
        .in_mask(in_mask),
`endif
        .e(e1), .i(i1), .s(s1), .busy(busy1), .done(done1)
    );

    task automatic push(input int inst, input obs_t r);
        if (inst == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    // Expected trace of one accepted frame, starting the cycle after acceptance.
    task automatic push_frame(input int inst, input int dwell, input bit lsb,
                              input logic [15:0] data, input logic [15:0] mask);
        for (int p = 0; p < 16; p++) begin
            int ch = lsb ? p : 15 - p;
            if (!mask[ch]) begin
                for (int k = 0; k < dwell; k++)
                    push(inst, {1'b0, data[ch], 4'(ch), 1'b1, 1'b0, 1'b0});
            end
        end
        push(inst, {1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0});
        push(inst, IDLE_OBS);
    endtask

    task automatic check(input int inst, input obs_t act, input obs_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL out%0d cyc=%0d got e=%b i=%b s=%0d busy=%b done=%b rdy=%b want e=%b i=%b s=%0d busy=%b done=%b rdy=%b",
                      inst, cyc, act.e, act.i, act.s, act.busy, act.done, act.rdy,
                      exp.e, exp.i, exp.s, exp.busy, exp.done, exp.rdy);
    endtask

    // Monitor: every cycle pop the expected record (idle when none pending).
    always @(posedge clk) begin
        obs_t a0, a1, x0, x1;
        #1;
        a0 = {e0, i0, s0, busy0, done0, rdy0};
        a1 = {e1, i1, s1, busy1, done1, rdy1};
        x0 = (q0.size() > 0) ? q0.pop_front() : IDLE_OBS;
        x1 = (q1.size() > 0) ? q1.pop_front() : IDLE_OBS;
        check(0, a0, x0);
        check(1, a1, x1);
        cyc++;
    end

    // Drive one cycle of inputs and let the model decide acceptance.
    task automatic drive(input bit r, input bit v, input logic [15:0] d,
                         input logic [15:0] m, output bit acc0);
        logic [15:0] m_eff;
        @(negedge clk);
`ifdef DEMUX_SCAN_MASK_EN
        in_mask = m;
        m_eff   = m;
`else
        m_eff   = 16'h0000;
`endif
        rst      = r;
        in_valid = v;
        in_data  = d;
        acc0     = 1'b0;
        if (r) begin
            q0.delete();
            q1.delete();
        end else if (v) begin
            if (q0.size() == 0) begin
                push_frame(0, 1, 1'b1, d, m_eff);
                acc0 = 1'b1;
            end
            if (q1.size() == 0) push_frame(1, 3, 1'b0, d, m_eff);
        end
    endtask

    task automatic drain();
        bit a;
        for (int n = 0; n < 300 && (q0.size() > 0 || q1.size() > 0); n++)
            drive(1'b0, 1'b0, 16'($urandom), 16'h0000, a);
    endtask

    initial begin
        logic [15:0] frames [4];
        logic [15:0] m;
        bit          acc;
        frames[0] = 16'hA5C3;
        frames[1] = 16'h8001;
        frames[2] = 16'hFFFF;
        frames[3] = 16'h0000;

        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hA5C3;
`ifdef DEMUX_SCAN_MASK_EN
        in_mask  = 16'h0000;
`endif
        // Reset held with in_valid high: nothing may be accepted.
        drive(1'b1, 1'b1, 16'hA5C3, 16'h0000, acc);
        drive(1'b1, 1'b1, 16'hA5C3, 16'h0000, acc);

        // Directed frames, offered back-to-back with in_valid held high.
        for (int f = 0; f < 4; f++) begin
            acc = 1'b0;
            for (int n = 0; n < 200 && !acc; n++)
                drive(1'b0, 1'b1, frames[f], 16'h0000, acc);
        end
        drain();

        // Reset while the ascending instance shows s=7.
        drive(1'b0, 1'b1, 16'($urandom), 16'h0000, acc);
        for (int n = 0; n < 7; n++) drive(1'b0, 1'b0, 16'($urandom), 16'h0000, acc);
        drive(1'b1, 1'b0, 16'($urandom), 16'h0000, acc);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, acc);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, acc);

`ifdef DEMUX_SCAN_MASK_EN
        drive(1'b0, 1'b1, 16'h0001, 16'hFFFE, acc);
        drain();
        drive(1'b0, 1'b1, 16'hA5A5, 16'hFFFF, acc);
        drain();
`endif

        // Randomized traffic with occasional resets and changing data.
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 3))
                0:       m = 16'h0000;
                1:       m = 16'($urandom);
                2:       m = 16'($urandom) | 16'($urandom) | 16'($urandom);
                default: m = 16'hFFFF;
            endcase
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
                  16'($urandom), m, acc);
        end
        drain();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, acc);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
